// File: rtl/floo_axi_sub_responder.sv
// AXI subordinate responder: accepts one write and one read burst at a time, answers after a
// fixed latency, returns the beat address as read data and counts completed transactions.
module floo_axi_sub_responder #(
    parameter int unsigned AddrWidth   = 48,
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned IdWidth     = 4,
    parameter int unsigned RespLatency = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,
    input  logic [IdWidth-1:0]   aw_id_i,
    input  logic [AddrWidth-1:0] aw_addr_i,
    input  logic [7:0]           aw_len_i,
    input  logic [2:0]           aw_size_i,
    input  logic [1:0]           aw_burst_i,
    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    input  logic                 w_last_i,
    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    output logic [IdWidth-1:0]   b_id_o,
    output logic [1:0]           b_resp_o,
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    input  logic [IdWidth-1:0]   ar_id_i,
    input  logic [AddrWidth-1:0] ar_addr_i,
    input  logic [7:0]           ar_len_i,
    input  logic [2:0]           ar_size_i,
    input  logic [1:0]           ar_burst_i,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    output logic [IdWidth-1:0]   r_id_o,
    output logic [DataWidth-1:0] r_data_o,
    output logic [1:0]           r_resp_o,
    output logic                 r_last_o,
    output logic [31:0]          num_writes_o,
    output logic [31:0]          num_reads_o
);

    localparam int unsigned LatWidth = 8;
    localparam int unsigned BeatWidth = 9;
    localparam logic [LatWidth-1:0] LatLast =
        (RespLatency == 0) ? LatWidth'(0) : LatWidth'(RespLatency - 1);
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] BurstIncr  = 2'b01;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

    // The write address payload is accepted but plays no role in the response.
    logic unused_aw;
    assign unused_aw = ^{aw_addr_i, aw_size_i, aw_burst_i};

    w_state_e               w_state_q, w_state_d;
    logic [IdWidth-1:0]     aw_id_q, aw_id_d;
    logic [7:0]             aw_len_q, aw_len_d;
    logic [BeatWidth-1:0]   w_beat_q, w_beat_d;
    logic                   w_err_q, w_err_d;
    logic [LatWidth-1:0]    w_cnt_q, w_cnt_d;
    logic [31:0]            num_writes_q, num_writes_d;

    r_state_e               r_state_q, r_state_d;
    logic [IdWidth-1:0]     ar_id_q, ar_id_d;
    logic [AddrWidth-1:0]   ar_addr_q, ar_addr_d;
    logic [7:0]             ar_len_q, ar_len_d;
    logic [2:0]             ar_size_q, ar_size_d;
    logic [1:0]             ar_burst_q, ar_burst_d;
    logic [7:0]             r_beat_q, r_beat_d;
    logic [LatWidth-1:0]    r_cnt_q, r_cnt_d;
    logic [31:0]            num_reads_q, num_reads_d;

    // Write path; beat count saturates one past the largest legal index so overruns stay visible.
    always_comb begin
        w_state_d    = w_state_q;
        aw_id_d      = aw_id_q;
        aw_len_d     = aw_len_q;
        w_beat_d     = w_beat_q;
        w_err_d      = w_err_q;
        w_cnt_d      = w_cnt_q;
        num_writes_d = num_writes_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_valid_i) begin
                    aw_id_d   = aw_id_i;
                    aw_len_d  = aw_len_i;
                    w_beat_d  = '0;
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (w_valid_i) begin
                    if ((w_beat_q > {1'b0, aw_len_q}) ||
                        (w_last_i && (w_beat_q != {1'b0, aw_len_q}))) begin
                        w_err_d = 1'b1;
                    end
                    if (!w_beat_q[BeatWidth-1]) begin
                        w_beat_d = w_beat_q + BeatWidth'(1);
                    end
                    if (w_last_i) begin
                        w_cnt_d   = '0;
                        w_state_d = (RespLatency == 0) ? W_RESP : W_WAIT;
                    end
                end
            end
            W_WAIT: begin
                if (w_cnt_q == LatLast) begin
                    w_state_d = W_RESP;
                end else begin
                    w_cnt_d = w_cnt_q + LatWidth'(1);
                end
            end
            W_RESP: begin
                if (b_ready_i) begin
                    num_writes_d = num_writes_q + 32'd1;
                    w_state_d    = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read path; only INCR advances the address, WRAP and reserved hold it and flag SLVERR.
    always_comb begin
        r_state_d   = r_state_q;
        ar_id_d     = ar_id_q;
        ar_addr_d   = ar_addr_q;
        ar_len_d    = ar_len_q;
        ar_size_d   = ar_size_q;
        ar_burst_d  = ar_burst_q;
        r_beat_d    = r_beat_q;
        r_cnt_d     = r_cnt_q;
        num_reads_d = num_reads_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_valid_i) begin
                    ar_id_d    = ar_id_i;
                    ar_addr_d  = ar_addr_i;
                    ar_len_d   = ar_len_i;
                    ar_size_d  = ar_size_i;
                    ar_burst_d = ar_burst_i;
                    r_beat_d   = '0;
                    r_cnt_d    = '0;
                    r_state_d  = (RespLatency == 0) ? R_DATA : R_WAIT;
                end
            end
            R_WAIT: begin
                if (r_cnt_q == LatLast) begin
                    r_state_d = R_DATA;
                end else begin
                    r_cnt_d = r_cnt_q + LatWidth'(1);
                end
            end
            R_DATA: begin
                if (r_ready_i) begin
                    if (r_beat_q == ar_len_q) begin
                        num_reads_d = num_reads_q + 32'd1;
                        r_state_d   = R_IDLE;
                    end else begin
                        r_beat_d = r_beat_q + 8'd1;
                        if (ar_burst_q == BurstIncr) begin
                            ar_addr_d = ar_addr_q + (AddrWidth'(1) << ar_size_q);
                        end
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state_q    <= W_IDLE;
            aw_id_q      <= '0;
            aw_len_q     <= '0;
            w_beat_q     <= '0;
            w_err_q      <= 1'b0;
            w_cnt_q      <= '0;
            num_writes_q <= '0;
            r_state_q    <= R_IDLE;
            ar_id_q      <= '0;
            ar_addr_q    <= '0;
            ar_len_q     <= '0;
            ar_size_q    <= '0;
            ar_burst_q   <= '0;
            r_beat_q     <= '0;
            r_cnt_q      <= '0;
            num_reads_q  <= '0;
        end else begin
            w_state_q    <= w_state_d;
            aw_id_q      <= aw_id_d;
            aw_len_q     <= aw_len_d;
            w_beat_q     <= w_beat_d;
            w_err_q      <= w_err_d;
            w_cnt_q      <= w_cnt_d;
            num_writes_q <= num_writes_d;
            r_state_q    <= r_state_d;
            ar_id_q      <= ar_id_d;
            ar_addr_q    <= ar_addr_d;
            ar_len_q     <= ar_len_d;
            ar_size_q    <= ar_size_d;
            ar_burst_q   <= ar_burst_d;
            r_beat_q     <= r_beat_d;
            r_cnt_q      <= r_cnt_d;
            num_reads_q  <= num_reads_d;
        end
    end

    // Handshake and payload outputs decode from state; reset forces them quiet immediately.
    assign aw_ready_o   = !rst_i && (w_state_q == W_IDLE);
    assign w_ready_o    = !rst_i && (w_state_q == W_DATA);
    assign b_valid_o    = !rst_i && (w_state_q == W_RESP);
    assign b_id_o       = rst_i ? '0 : aw_id_q;
    assign b_resp_o     = (rst_i || !w_err_q) ? RespOkay : RespSlvErr;

    assign ar_ready_o   = !rst_i && (r_state_q == R_IDLE);
    assign r_valid_o    = !rst_i && (r_state_q == R_DATA);
    assign r_id_o       = rst_i ? '0 : ar_id_q;
    assign r_data_o     = rst_i ? '0 : DataWidth'(ar_addr_q);
    assign r_resp_o     = (rst_i || !ar_burst_q[1]) ? RespOkay : RespSlvErr;
    assign r_last_o     = !rst_i && (r_state_q == R_DATA) && (r_beat_q == ar_len_q);

    assign num_writes_o = num_writes_q;
    assign num_reads_o  = num_reads_q;

endmodule
